// File: rtl/disp_pkg.sv
// disp_pkg: shared encodings for the display input block.
// Holds the Ctl display-mode encodings, the auto-repeat state type and
// the address stepping helpers used by disp_input.
package disp_pkg;

    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        CTL_REG   = 2'b00,
        CTL_MEM   = 2'b01,
        CTL_INSTR = 2'b10
    } ctl_e;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'b00,
        REP_HOLD   = 2'b01,
        REP_REPEAT = 2'b10
    } rep_state_e;

    // Mode button walks register -> memory -> instruction -> register.
    function automatic ctl_e nextCtl(input ctl_e ctl);
        ctl_e result;
        case (ctl)
            CTL_REG: result = CTL_MEM;
            CTL_MEM: result = CTL_INSTR;
            default: result = CTL_REG;
        endcase
        return result;
    endfunction

    // Register view wraps in 0..31 with the top two bits pinned low,
    // memory view wraps in 0..127, instruction view never moves.
    function automatic logic [ADDR_W-1:0] stepAddr(input ctl_e ctl,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic up);
        logic [ADDR_W-1:0] result;
        logic [4:0]        low;
        result = addr;
        low    = addr[4:0];
        case (ctl)
            CTL_REG: begin
                low    = up ? (low + 5'd1) : (low - 5'd1);
                result = {2'b00, low};
            end
            CTL_MEM: result = up ? (addr + 7'd1) : (addr - 7'd1);
            default: result = addr;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus stability counter for one
// raw push-button. The debounced level flips only after DEBOUNCE_CYCLES
// consecutive synchronized samples disagree with the current level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer chain, debounced level and counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/disp_input.sv
// disp_input: turns three raw push-buttons into a display mode (Ctl),
// an address (Addr) and a one-cycle Changed pulse.
// Optional feature: define DISP_INPUT_REPEAT_EN to compile in auto-repeat
// of held Up/Down buttons; without it one press gives exactly one step.
module disp_input
    import disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              btnUp_i,
    input  logic              btnDown_i,
    input  logic              btnMode_i,
    output logic [1:0]        ctl_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              changed_o
);

    logic upLvl;
    logic downLvl;
    logic modeLvl;
    logic upPrev_q;
    logic downPrev_q;
    logic modePrev_q;

    logic upRise;
    logic downRise;
    logic modeRise;
    logic upStep;
    logic downStep;
    logic edgeStep;
    logic repStep;
    logic repUp;

    ctl_e              ctl_q;
    ctl_e              ctl_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              changed_q;
    logic              changed_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebUp (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (btnUp_i),
        .level_o (upLvl)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebDown (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (btnDown_i),
        .level_o (downLvl)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebMode (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (btnMode_i),
        .level_o (modeLvl)
    );

    // Rising edges only; a step is refused while the opposite button is
    // held, and a Mode edge in the same cycle swallows the step.
    always_comb begin
        upRise   = upLvl & ~upPrev_q;
        downRise = downLvl & ~downPrev_q;
        modeRise = modeLvl & ~modePrev_q;
        upStep   = upRise & ~downLvl;
        downStep = downRise & ~upLvl;
        edgeStep = (upStep | downStep) & ~modeRise;
    end

`ifdef DISP_INPUT_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    rep_state_e       repState_q;
    rep_state_e       repState_d;
    logic [REP_W-1:0] repCnt_q;
    logic [REP_W-1:0] repCnt_d;
    logic             repDirUp_q;
    logic             repDirUp_d;
    logic             heldLvl;
    logic             cancel;

    // Repeat FSM: a fresh edge step (re)arms HOLD; release, both buttons
    // or a Mode edge drop back to IDLE; timers fire the extra steps.
    always_comb begin
        repState_d = repState_q;
        repCnt_d   = repCnt_q;
        repDirUp_d = repDirUp_q;
        repStep    = 1'b0;
        repUp      = repDirUp_q;
        heldLvl    = repDirUp_q ? upLvl : downLvl;
        cancel     = ~heldLvl | (upLvl & downLvl) | modeRise;
        if (edgeStep) begin
            repState_d = REP_HOLD;
            repCnt_d   = '0;
            repDirUp_d = upStep;
        end else begin
            case (repState_q)
                REP_HOLD: begin
                    if (cancel) begin
                        repState_d = REP_IDLE;
                        repCnt_d   = '0;
                    end else if (repCnt_q == DELAY_LAST) begin
                        repState_d = REP_REPEAT;
                        repCnt_d   = '0;
                        repStep    = 1'b1;
                    end else begin
                        repCnt_d = repCnt_q + 1'b1;
                    end
                end
                REP_REPEAT: begin
                    if (cancel) begin
                        repState_d = REP_IDLE;
                        repCnt_d   = '0;
                    end else if (repCnt_q == RATE_LAST) begin
                        repCnt_d = '0;
                        repStep  = 1'b1;
                    end else begin
                        repCnt_d = repCnt_q + 1'b1;
                    end
                end
                default: begin
                    repState_d = REP_IDLE;
                    repCnt_d   = '0;
                end
            endcase
        end
    end

    // Repeat FSM state, timer and direction registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            repState_q <= REP_IDLE;
            repCnt_q   <= '0;
            repDirUp_q <= 1'b0;
        end else begin
            repState_q <= repState_d;
            repCnt_q   <= repCnt_d;
            repDirUp_q <= repDirUp_d;
        end
    end
`else
    assign repStep = 1'b0;
    assign repUp   = 1'b0;
`endif

    // Next mode/address; Changed is raised only when something really moves.
    always_comb begin
        ctl_d  = ctl_q;
        addr_d = addr_q;
        if (modeRise) begin
            ctl_d  = nextCtl(ctl_q);
            addr_d = '0;
        end else if (edgeStep) begin
            addr_d = stepAddr(ctl_q, addr_q, upStep);
        end else if (repStep) begin
            addr_d = stepAddr(ctl_q, addr_q, repUp);
        end
        changed_d = (ctl_d != ctl_q) || (addr_d != addr_q);
    end

    // Output registers and previous debounced levels for edge detection.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctl_q      <= CTL_REG;
            addr_q     <= '0;
            changed_q  <= 1'b0;
            upPrev_q   <= 1'b0;
            downPrev_q <= 1'b0;
            modePrev_q <= 1'b0;
        end else begin
            ctl_q      <= ctl_d;
            addr_q     <= addr_d;
            changed_q  <= changed_d;
            upPrev_q   <= upLvl;
            downPrev_q <= downLvl;
            modePrev_q <= modeLvl;
        end
    end

    assign ctl_o     = ctl_q;
    assign addr_o    = addr_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_disp_input.sv
// tb_disp_input: directed bench for disp_input with a cycle-level
// behavioural model plus hand-computed checkpoints.
// Honours DISP_INPUT_REPEAT_EN the same way the design does.
module tb_disp_input;

    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int RATE = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnUp;
    logic       btnDown;
    logic       btnMode;
    logic [1:0] ctl;
    logic [6:0] addr;
    logic       changed;

    int checks   = 0;
    int failures = 0;

    int              expCtl;
    int              expAddr;
    bit              expChanged;
    bit              modelValid = 1'b0;
    bit [DEB+1:0]    rawHist [3];
    bit              lvl [3];
    bit              plvl [3];
    bit              repActive;
    bit              repDirUp;
    int              pressEdge;
    int              edgeNum;

    disp_input #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_RATE     (RATE)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .btnUp_i   (btnUp),
        .btnDown_i (btnDown),
        .btnMode_i (btnMode),
        .ctl_o     (ctl),
        .addr_o    (addr),
        .changed_o (changed)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int modelStep(input int mode, input int a, input bit up);
        if (mode == 0) return up ? (a + 1) % 32 : (a + 31) % 32;
        if (mode == 1) return up ? (a + 1) % 128 : (a + 127) % 128;
        return a;
    endfunction

    // Behavioural model: debounced level flips once the last DEB samples
    // seen two cycles late all disagree with it; a level that rose on the
    // previous edge acts on this one.
    always @(posedge clk) begin : model
        bit rUp, rDown, rMode, upStep, downStep, edgeStep, doRep, held, allDiff;
        bit raws [3];
        int oldCtl, oldAddr, k;
        if (reset) begin
            expCtl     = 0;
            expAddr    = 0;
            expChanged = 1'b0;
            for (int b = 0; b < 3; b++) begin
                rawHist[b] = '0;
                lvl[b]     = 1'b0;
                plvl[b]    = 1'b0;
            end
            repActive  = 1'b0;
            edgeNum    = 0;
            modelValid = 1'b1;
        end else begin
            edgeNum++;
            rUp      = lvl[0] && !plvl[0];
            rDown    = lvl[1] && !plvl[1];
            rMode    = lvl[2] && !plvl[2];
            upStep   = rUp && !lvl[1];
            downStep = rDown && !lvl[0];
            edgeStep = (upStep || downStep) && !rMode;
            oldCtl   = expCtl;
            oldAddr  = expAddr;
            doRep    = 1'b0;
`ifdef DISP_INPUT_REPEAT_EN
            if (edgeStep) begin
                repActive = 1'b1;
                pressEdge = edgeNum;
                repDirUp  = upStep;
            end else if (repActive) begin
                held = repDirUp ? lvl[0] : lvl[1];
                if (!held || (lvl[0] && lvl[1]) || rMode) begin
                    repActive = 1'b0;
                end else begin
                    k = edgeNum - pressEdge;
                    if (k >= DLY && ((k - DLY) % RATE) == 0) doRep = 1'b1;
                end
            end
`endif
            if (rMode) begin
                expCtl  = (expCtl + 1) % 3;
                expAddr = 0;
            end else if (edgeStep) begin
                expAddr = modelStep(expCtl, expAddr, upStep);
            end else if (doRep) begin
                expAddr = modelStep(expCtl, expAddr, repDirUp);
            end
            expChanged = (expCtl != oldCtl) || (expAddr != oldAddr);
            raws[0] = btnUp;
            raws[1] = btnDown;
            raws[2] = btnMode;
            for (int b = 0; b < 3; b++) begin
                plvl[b]    = lvl[b];
                rawHist[b] = {rawHist[b][DEB:0], raws[b]};
                allDiff    = 1'b1;
                for (int i = 2; i <= DEB + 1; i++)
                    if (rawHist[b][i] == lvl[b]) allDiff = 1'b0;
                if (allDiff) lvl[b] = !lvl[b];
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("modelCtl", 32'(ctl), expCtl);
            checkOutput("modelAddr", 32'(addr), expAddr);
            checkOutput("modelChanged", 32'(changed), 32'(expChanged));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit up, input bit down, input bit mode,
                                 input int hold, input int settle);
        btnUp   = up;
        btnDown = down;
        btnMode = mode;
        tick(hold);
        btnUp   = 1'b0;
        btnDown = 1'b0;
        btnMode = 1'b0;
        tick(settle);
    endtask

    // Directed sequence with hand-computed checkpoints.
    initial begin
        reset   = 1'b1;
        btnUp   = 1'b0;
        btnDown = 1'b0;
        btnMode = 1'b0;
        tick(2);
        checkOutput("resetCtl", 32'(ctl), 0);
        checkOutput("resetAddr", 32'(addr), 0);
        checkOutput("resetChanged", 32'(changed), 0);
        reset = 1'b0;

        applyStimulus(1, 0, 0, 3, 12);
        checkOutput("shortPressAddr", 32'(addr), 0);

        btnUp = 1'b1;
        tick(6);
        checkOutput("latencyBefore", 32'(addr), 0);
        tick(1);
        checkOutput("latencyAddr", 32'(addr), 1);
        checkOutput("latencyChanged", 32'(changed), 1);
        tick(1);
        checkOutput("latencyPulseEnd", 32'(changed), 0);
        tick(2);
        btnUp = 1'b0;
        tick(12);

        applyStimulus(0, 1, 0, 10, 12);
        applyStimulus(0, 1, 0, 10, 12);
        checkOutput("regWrapDown", 32'(addr), 31);
        applyStimulus(1, 0, 0, 10, 12);
        checkOutput("regWrapUp", 32'(addr), 0);
        applyStimulus(0, 1, 0, 10, 12);
        checkOutput("regWrapDown2", 32'(addr), 31);
        applyStimulus(0, 0, 1, 10, 12);
        checkOutput("modeMemCtl", 32'(ctl), 1);
        checkOutput("modeMemAddr", 32'(addr), 0);
        applyStimulus(0, 1, 0, 10, 12);
        checkOutput("memWrapDown", 32'(addr), 127);
        applyStimulus(1, 0, 0, 10, 12);
        checkOutput("memWrapUp", 32'(addr), 0);

        applyStimulus(0, 0, 1, 10, 12);
        checkOutput("modeInstrCtl", 32'(ctl), 2);
        applyStimulus(1, 0, 0, 10, 12);
        applyStimulus(0, 1, 0, 10, 12);
        checkOutput("instrAddrHeld", 32'(addr), 0);
        applyStimulus(0, 0, 1, 10, 12);
        checkOutput("modeRegCtl", 32'(ctl), 0);

        applyStimulus(1, 0, 0, 10, 12);
        applyStimulus(1, 1, 0, 10, 12);
        checkOutput("bothHeldAddr", 32'(addr), 1);

        for (int i = 0; i < 20; i++) begin
            btnUp = ~btnUp;
            tick(1);
        end
        applyStimulus(1, 0, 0, 10, 12);
        checkOutput("bounceAddr", 32'(addr), 2);

        applyStimulus(0, 0, 1, 10, 12);
        checkOutput("repeatSetupCtl", 32'(ctl), 1);
        applyStimulus(1, 0, 0, 50, 12);
`ifdef DISP_INPUT_REPEAT_EN
        checkOutput("holdAddr", 32'(addr), 7);
`else
        checkOutput("holdAddr", 32'(addr), 1);
`endif

        btnUp = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(2);
        checkOutput("midResetCtl", 32'(ctl), 0);
        checkOutput("midResetAddr", 32'(addr), 0);
        checkOutput("midResetChanged", 32'(changed), 0);
        reset = 1'b0;
        tick(10);
        btnUp = 1'b0;
        tick(12);
        checkOutput("postResetAddr", 32'(addr), 1);
        checkOutput("postResetCtl", 32'(ctl), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
